// File: rtl/modulation_multiplier_pipe.sv
`default_nettype none
// =============================================================================
// modulation_multiplier_pipe : per-frame modulation fetch + intensity multiplier
// Revision: 1.0
// =============================================================================
module modulation_multiplier_pipe #(
    parameter int DEPTH           = 249,
    parameter int INTENSITY_WIDTH = 8,
    parameter int MOD_WIDTH       = 8,
    parameter int PHASE_WIDTH     = 8,
    parameter int IDX_WIDTH       = 15,
    parameter int MOD_RD_LATENCY  = 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 DIN_VALID,
    input  logic [INTENSITY_WIDTH-1:0]           INTENSITY_IN,
    input  logic [PHASE_WIDTH-1:0]               PHASE_IN,
    output logic [INTENSITY_WIDTH+MOD_WIDTH-1:0] INTENSITY_OUT,
    output logic [PHASE_WIDTH-1:0]               PHASE_OUT,
    output logic                                 DOUT_VALID,
    output logic [IDX_WIDTH-1:0]                 MOD_IDX,
    output logic                                 MOD_SEGMENT,
    input  logic [MOD_WIDTH-1:0]                 MOD_VALUE,
    input  logic [IDX_WIDTH-1:0]                 IDX_0,
    input  logic [IDX_WIDTH-1:0]                 IDX_1,
    input  logic                                 SEGMENT,
    input  logic                                 STOP,
    input  logic                                 BYPASS,
    output logic                                 BUSY,
    output logic                                 FRAME_DROP,
    output logic [IDX_WIDTH-1:0]                 DEBUG_IDX,
    output logic                                 DEBUG_SEGMENT,
    output logic                                 DEBUG_STOP
);

    localparam int c_lat     = MOD_RD_LATENCY + 3;
    localparam int c_int_dly = MOD_RD_LATENCY + 2;
    localparam int c_prod_w  = INTENSITY_WIDTH + MOD_WIDTH;
    localparam int c_cnt_max = (DEPTH > MOD_RD_LATENCY) ? DEPTH : MOD_RD_LATENCY;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_fetch = c_cnt_w'(MOD_RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [c_cnt_w-1:0]           cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic                         seg_q, seg_d;
    logic                         stop_q, stop_d;
    logic                         byp_q, byp_d;
    logic                         drop_q, drop_d;
    logic [MOD_WIDTH-1:0]         mod_q, mod_d;
    logic [c_prod_w-1:0]          prod_q, prod_d;
    logic [INTENSITY_WIDTH-1:0]   int_dly_q [c_int_dly];
    logic [INTENSITY_WIDTH-1:0]   int_dly_d [c_int_dly];
    logic [PHASE_WIDTH-1:0]       ph_dly_q  [c_lat];
    logic [PHASE_WIDTH-1:0]       ph_dly_d  [c_lat];

    // FETCH counts MOD_RD_LATENCY..0, RUN counts DEPTH..0 (last output at count 0)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        stop_d  = stop_q;
        byp_d   = byp_q;
        mod_d   = mod_q;
        drop_d  = DIN_VALID && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (DIN_VALID) begin
                    state_d = ST_FETCH;
                    cnt_d   = c_fetch;
                    stop_d  = STOP;
                    byp_d   = BYPASS;
                    if (!STOP) begin
                        idx_d = SEGMENT ? IDX_1 : IDX_0;
                        seg_d = SEGMENT;
                    end
                end
            end
            ST_FETCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = c_depth;
                    mod_d   = byp_q ? '1 : MOD_VALUE;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_dly_d[0] = INTENSITY_IN;
        for (int i = 1; i < c_int_dly; i++) begin
            int_dly_d[i] = int_dly_q[i-1];
        end
        ph_dly_d[0] = PHASE_IN;
        for (int i = 1; i < c_lat; i++) begin
            ph_dly_d[i] = ph_dly_q[i-1];
        end
        prod_d = c_prod_w'(int_dly_q[c_int_dly-1]) * c_prod_w'(mod_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 1'b0;
            stop_q    <= 1'b0;
            byp_q     <= 1'b0;
            drop_q    <= 1'b0;
            mod_q     <= '0;
            prod_q    <= '0;
            int_dly_q <= '{default: '0};
            ph_dly_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            stop_q    <= stop_d;
            byp_q     <= byp_d;
            drop_q    <= drop_d;
            mod_q     <= mod_d;
            prod_q    <= prod_d;
            int_dly_q <= int_dly_d;
            ph_dly_q  <= ph_dly_d;
        end
    end

    assign INTENSITY_OUT = prod_q;
    assign PHASE_OUT     = ph_dly_q[c_lat-1];
    assign DOUT_VALID    = (state_q == ST_RUN) && (cnt_q < c_depth);
    assign BUSY          = (state_q != ST_IDLE);
    assign FRAME_DROP    = drop_q;
    assign MOD_IDX       = idx_q;
    assign MOD_SEGMENT   = seg_q;
    assign DEBUG_IDX     = idx_q;
    assign DEBUG_SEGMENT = seg_q;
    assign DEBUG_STOP    = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_modulation_multiplier_pipe.sv
`default_nettype none
// =============================================================================
// tb_modulation_multiplier_pipe : directed scoreboard bench for the modulation stage
// Revision: 1.0
// =============================================================================
module tb_modulation_multiplier_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: defaults except DEPTH=4, latency 2 -> L=5
    logic        a_din_valid = 0, a_seg = 0, a_stop = 0, a_byp = 0;
    logic [7:0]  a_int_in = 0, a_ph_in = 0, a_ph_out, a_mod_value;
    logic [15:0] a_int_out;
    logic [14:0] a_idx0 = 0, a_idx1 = 0, a_mod_idx, a_dbg_idx;
    logic        a_dout_valid, a_mod_seg, a_busy, a_frame_drop, a_dbg_seg, a_dbg_stop;

    modulation_multiplier_pipe #(.DEPTH(4), .MOD_RD_LATENCY(2)) u_dut_a (
        .CLK(clk), .RST(rst), .DIN_VALID(a_din_valid), .INTENSITY_IN(a_int_in),
        .PHASE_IN(a_ph_in), .INTENSITY_OUT(a_int_out), .PHASE_OUT(a_ph_out),
        .DOUT_VALID(a_dout_valid), .MOD_IDX(a_mod_idx), .MOD_SEGMENT(a_mod_seg),
        .MOD_VALUE(a_mod_value), .IDX_0(a_idx0), .IDX_1(a_idx1), .SEGMENT(a_seg),
        .STOP(a_stop), .BYPASS(a_byp), .BUSY(a_busy), .FRAME_DROP(a_frame_drop),
        .DEBUG_IDX(a_dbg_idx), .DEBUG_SEGMENT(a_dbg_seg), .DEBUG_STOP(a_dbg_stop)
    );

    // instance B: DEPTH=1, wide operands, latency 1 -> L=4
    logic        b_din_valid = 0, b_seg = 0, b_stop = 0, b_byp = 0;
    logic [9:0]  b_int_in = 0;
    logic [11:0] b_mod_value = 0;
    logic [21:0] b_int_out;
    logic [7:0]  b_ph_in = 0, b_ph_out;
    logic [14:0] b_idx0 = 0, b_idx1 = 0, b_mod_idx, b_dbg_idx;
    logic        b_dout_valid, b_mod_seg, b_busy, b_frame_drop, b_dbg_seg, b_dbg_stop;

    modulation_multiplier_pipe #(.DEPTH(1), .INTENSITY_WIDTH(10), .MOD_WIDTH(12),
                                 .MOD_RD_LATENCY(1)) u_dut_b (
        .CLK(clk), .RST(rst), .DIN_VALID(b_din_valid), .INTENSITY_IN(b_int_in),
        .PHASE_IN(b_ph_in), .INTENSITY_OUT(b_int_out), .PHASE_OUT(b_ph_out),
        .DOUT_VALID(b_dout_valid), .MOD_IDX(b_mod_idx), .MOD_SEGMENT(b_mod_seg),
        .MOD_VALUE(b_mod_value), .IDX_0(b_idx0), .IDX_1(b_idx1), .SEGMENT(b_seg),
        .STOP(b_stop), .BYPASS(b_byp), .BUSY(b_busy), .FRAME_DROP(b_frame_drop),
        .DEBUG_IDX(b_dbg_idx), .DEBUG_SEGMENT(b_dbg_seg), .DEBUG_STOP(b_dbg_stop)
    );

    function automatic logic [7:0] mem_a(input logic seg, input logic [14:0] idx);
        if (seg) return 8'(idx * 11 + 1);
        if (idx == 15'd5) return 8'd128;
        if (idx == 15'd2) return 8'd7;
        return 8'(idx + 40);
    endfunction

    function automatic logic [11:0] mem_b(input logic [14:0] idx);
        return (idx == 15'd6) ? 12'd4095 : idx[11:0];
    endfunction

    // modulation BRAM models with the configured read latency
    logic [7:0] a_bram_pipe [2];
    always @(posedge clk) begin
        a_bram_pipe[0] <= mem_a(a_mod_seg, a_mod_idx);
        a_bram_pipe[1] <= a_bram_pipe[0];
        b_mod_value    <= mem_b(b_mod_idx);
    end
    assign a_mod_value = a_bram_pipe[1];

    typedef struct {
        int          at;
        logic [15:0] val;
        logic [7:0]  ph;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (a_dout_valid) begin
            checks++;
            if (sb.size() == 0) begin
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_dout cyc=%0d observed=valid expected=idle", cyc);
                end
            end else begin
                e = sb.pop_front();
                assert (a_int_out === e.val && a_ph_out === e.ph && cyc == e.at) else begin
                    errors++;
                    $error("FAIL dout cyc=%0d observed int=%0d ph=%0d expected int=%0d ph=%0d at cyc=%0d",
                           cyc, a_int_out, a_ph_out, e.val, e.ph, e.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    logic [7:0]  ins [4];
    logic [14:0] m_idx = 0;
    logic        m_seg = 0, m_stop = 0;

    // drives one DEPTH=4 frame on instance A; drop_at>0 re-strobes DIN_VALID mid-frame
    task automatic frame(input int tag, input logic seg, input logic [14:0] x0, x1,
                         input logic stp, input logic byp, input int drop_at);
        int         t0;
        logic [7:0] mv;
        exp_t       e;
        t0 = cyc;
        if (!stp) begin
            m_idx = seg ? x1 : x0;
            m_seg = seg;
        end
        m_stop = stp;
        mv = byp ? 8'hFF : mem_a(m_seg, m_idx);
        for (int k = 0; k < 4; k++) begin
            e.at = t0 + k + 5;
            e.val = 16'(ins[k]) * 16'(mv);
            e.ph = 8'(tag * 16 + k);
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            a_din_valid = (k == 0) || (k == drop_at);
            a_int_in = ins[k];
            a_ph_in = 8'(tag * 16 + k);
            if (k == 0) begin
                a_seg = seg; a_idx0 = x0; a_idx1 = x1; a_stop = stp; a_byp = byp;
            end else begin
                a_seg = ~seg; a_idx0 = x0 + 1; a_idx1 = x1 + 1; a_stop = ~stp; a_byp = ~byp;
            end
            step();
            if (k == 0) begin
                chk("mod_idx", 32'(a_mod_idx), 32'(m_idx));
                chk("mod_segment", 32'(a_mod_seg), 32'(m_seg));
                chk("debug_idx", 32'(a_dbg_idx), 32'(m_idx));
                chk("debug_stop", 32'(a_dbg_stop), 32'(m_stop));
                chk("busy_start", 32'(a_busy), 32'd1);
                chk("no_drop", 32'(a_frame_drop), 32'd0);
            end
            if (k == drop_at) chk("frame_drop", 32'(a_frame_drop), 32'd1);
        end
        a_din_valid = 1'b0;
        for (int n = 0; n < 20 && cyc < t0 + 8; n++) step();
        chk("busy_last", 32'(a_busy), 32'd1);
        chk("mod_idx_stable", 32'(a_mod_idx), 32'(m_idx));
        step();
        chk("busy_done", 32'(a_busy), 32'd0);
    endtask

    initial begin
        int   t0;
        exp_t e;
        rst = 1'b1;
        step();
        step();
        chk("rst_dout_valid", 32'(a_dout_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_frame_drop", 32'(a_frame_drop), 32'd0);
        chk("rst_int_out", 32'(a_int_out), 32'd0);
        chk("rst_ph_out", 32'(a_ph_out), 32'd0);
        chk("rst_mod_idx", 32'(a_mod_idx), 32'd0);
        chk("rst_debug", 32'({a_dbg_idx, a_dbg_seg, a_dbg_stop, a_mod_seg}), 32'd0);
        rst = 1'b0;
        step();

        ins = '{8'd200, 8'd1, 8'd0, 8'd255};
        frame(1, 1'b0, 15'd5, 15'd0, 1'b0, 1'b0, -1);
        ins = '{8'd10, 8'd20, 8'd30, 8'd40};
        frame(2, 1'b1, 15'd4, 15'd9, 1'b0, 1'b0, -1);
        ins = '{8'd1, 8'd2, 8'd3, 8'd250};
        frame(3, 1'b0, 15'd3, 15'd6, 1'b1, 1'b0, 3);
        ins = '{8'd200, 8'd100, 8'd1, 8'd0};
        frame(4, 1'b0, 15'd2, 15'd0, 1'b0, 1'b1, -1);

        // reset in the middle of a frame: only samples 0 and 1 may appear
        t0 = cyc;
        ins = '{8'd50, 8'd60, 8'd70, 8'd80};
        m_idx = 15'd5; m_seg = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e.at = t0 + k + 5; e.val = 16'(ins[k]) * 16'd128; e.ph = 8'(96 + k);
            sb.push_back(e);
        end
        a_seg = 0; a_idx0 = 15'd5; a_stop = 0; a_byp = 0;
        for (int k = 0; k < 4; k++) begin
            a_din_valid = (k == 0);
            a_int_in = ins[k];
            a_ph_in = 8'(96 + k);
            step();
        end
        a_din_valid = 1'b0;
        for (int n = 0; n < 10 && cyc < t0 + 6; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_dout_valid", 32'(a_dout_valid), 32'd0);
        chk("midrst_int_out", 32'(a_int_out), 32'd0);
        chk("midrst_ph_out", 32'(a_ph_out), 32'd0);
        chk("midrst_mod_idx", 32'(a_mod_idx), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        m_idx = 0; m_seg = 0; m_stop = 0;
        step();
        step();
        ins = '{8'd255, 8'd2, 8'd3, 8'd4};
        frame(5, 1'b0, 15'd2, 15'd9, 1'b0, 1'b0, -1);

        // DEPTH=1 with wide operands
        t0 = cyc;
        b_din_valid = 1; b_int_in = 10'd1023; b_ph_in = 8'h3C; b_idx0 = 15'd6; b_byp = 0;
        step();
        b_din_valid = 0; b_int_in = 10'd0; b_ph_in = 8'd0;
        chk("b_mod_idx", 32'(b_mod_idx), 32'd6);
        for (int n = 0; n < 10 && cyc < t0 + 3; n++) step();
        chk("b_valid_before", 32'(b_dout_valid), 32'd0);
        step();
        chk("b_valid_at_l", 32'(b_dout_valid), 32'd1);
        chk("b_product", 32'(b_int_out), 32'd4189185);
        chk("b_phase", 32'(b_ph_out), 32'h3C);
        chk("b_busy_last", 32'(b_busy), 32'd1);
        step();
        chk("b_valid_after", 32'(b_dout_valid), 32'd0);
        chk("b_busy_done", 32'(b_busy), 32'd0);

        t0 = cyc;
        b_din_valid = 1; b_int_in = 10'd5; b_idx0 = 15'd7; b_byp = 1;
        step();
        b_din_valid = 0; b_byp = 0; b_int_in = 10'd0;
        for (int n = 0; n < 10 && cyc < t0 + 4; n++) step();
        chk("b_bypass_valid", 32'(b_dout_valid), 32'd1);
        chk("b_bypass_product", 32'(b_int_out), 32'd20475);

        step();
        step();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL missing_outputs observed=%0d pending expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulation_multiplier_pipe.md
# modulation_multiplier_pipe

Parametrised per-frame modulation stage between the intensity/phase source and the PWM stage. At each frame start it latches the active modulation segment and index and fetches one modulation sample from the modulation BRAM. It then streams DEPTH intensity/phase samples through, multiplying each intensity by that sample with a fixed, known latency. It generalises the fixed 8-bit/249-channel multiplier with these additions:
- configurable widths and BRAM read latency
- synchronous reset
- a bypass mode
- an explicit busy/overrun indication

## Interface
Parameters:
- DEPTH, 249: channels (samples) per frame, ≥1
- INTENSITY_WIDTH, 8: intensity input width
- MOD_WIDTH, 8: modulation sample width
- PHASE_WIDTH, 8: phase width
- IDX_WIDTH, 15: modulation index width
- MOD_RD_LATENCY, 2: cycles from MOD_IDX/MOD_SEGMENT change to valid MOD_VALUE, ≥1

Ports:
- CLK  in  1  single clock
- RST  in  1  reset; synchronous, active-high
- DIN_VALID  in  1  one-cycle frame-start strobe; sample 0 present on the same cycle
- INTENSITY_IN  in  INTENSITY_WIDTH  intensity of the current sample
- PHASE_IN  in  PHASE_WIDTH  phase of the current sample
- INTENSITY_OUT  out  INTENSITY_WIDTH+MOD_WIDTH  unsigned product
- PHASE_OUT  out  PHASE_WIDTH  phase, delayed to align with INTENSITY_OUT
- DOUT_VALID  out  1  output sample valid
- MOD_IDX  out  IDX_WIDTH  modulation BRAM address (registered)
- MOD_SEGMENT  out  1  modulation BRAM segment select (registered)
- MOD_VALUE  in  MOD_WIDTH  modulation BRAM read data
- IDX_0, IDX_1  in  IDX_WIDTH  current index of segment 0 and segment 1
- SEGMENT  in  1  active segment
- STOP  in  1  freeze the modulation index
- BYPASS  in  1  force the modulation factor to full scale
- BUSY  out  1  frame in progress
- FRAME_DROP  out  1  one-cycle pulse when DIN_VALID is ignored
- DEBUG_IDX  out  IDX_WIDTH  latched index
- DEBUG_SEGMENT  out  1  latched segment
- DEBUG_STOP  out  1  latched stop flag

## Operation
- Cycle numbering: cycle 0 is the cycle on which DIN_VALID is accepted. L = MOD_RD_LATENCY + 3.
- States:
  - IDLE → FETCH when DIN_VALID and not BUSY.
  - FETCH lasts MOD_RD_LATENCY+1 cycles → RUN.
  - RUN lasts until the DEPTH-th output → IDLE.
- Latching on the accepted DIN_VALID (cycle 0):
  - stop_buf ← STOP.
  - If STOP = 0: idx ← (SEGMENT ? IDX_1 : IDX_0) and segment_buf ← SEGMENT.
  - If STOP = 1: idx and segment_buf keep their previous values, so the previous sample is re-read.
  - bypass_buf ← BYPASS.
- mod_reg captures MOD_VALUE at the end of cycle MOD_RD_LATENCY+1. If bypass_buf = 1, mod_reg is loaded with all-ones instead.
- Intensity path:
  - Delayed MOD_RD_LATENCY+2 cycles, then multiplied by mod_reg.
  - The multiplier is unsigned with one registered stage.
  - The result is the full-width product with no rounding and no saturation.
- PHASE_IN is delayed exactly L cycles.
- Sample k (input on cycle k) appears on cycle k+L. DOUT_VALID is high on cycles L … L+DEPTH-1 inclusive and low otherwise.
- BUSY is high on cycles 1 … L+DEPTH-1. The next frame can be accepted at cycle L+DEPTH at the earliest.
- DIN_VALID while BUSY:
  - The strobe is ignored; the latched registers and the frame in progress are unaffected.
  - FRAME_DROP pulses high on the next cycle.
- DEBUG_* outputs mirror idx, segment_buf and stop_buf.

## Timing
- Reset values, all applied on the cycle after RST is sampled high:
  - DOUT_VALID = 0, BUSY = 0, FRAME_DROP = 0
  - INTENSITY_OUT = 0, PHASE_OUT = 0
  - MOD_IDX = 0, MOD_SEGMENT = 0, DEBUG_* = 0
  - mod_reg = 0, all delay lines = 0, state = IDLE
- RST mid-frame: the frame is aborted and DOUT_VALID is low from the next cycle. No partial samples appear after reset.
- RST takes priority over DIN_VALID on the same cycle.
- DIN_VALID on cycle L+DEPTH (BUSY low) is accepted, giving back-to-back frames with no gap in the pipeline.
- DEPTH = 1: DOUT_VALID is high for the single cycle L only.
- MOD_IDX changes only on the cycle after an accepted DIN_VALID with STOP = 0. It is stable for the whole frame.

## Test plan
- Basic frame: DEPTH=4, MOD_RD_LATENCY=2, IDX_0=5, SEGMENT=0, MOD_VALUE(seg0,5)=128, intensities 200,1,0,255 → MOD_IDX=5 from cycle 1; DOUT_VALID high on cycles 5–8; INTENSITY_OUT = 25600, 128, 0, 32640; phases delayed exactly 5 cycles.
- Segment and stop: frame A with SEGMENT=1, IDX_1=9 → MOD_SEGMENT=1, MOD_IDX=9. Frame B with STOP=1, SEGMENT=0, IDX_0=3 → MOD_IDX stays 9, MOD_SEGMENT stays 1, DEBUG_STOP=1.
- Bypass: BYPASS=1, intensity 200, MOD_VALUE=7 → INTENSITY_OUT = 51000 (200×255).
- Overrun: DIN_VALID on cycle 3 of a DEPTH=4 frame → FRAME_DROP high on cycle 4; output identical to the undisturbed frame. DIN_VALID on cycle 9 → accepted, outputs on cycles 14–17.
- Reset mid-frame: RST on cycle 6 → DOUT_VALID=0 from cycle 7; all outputs zero; the next DIN_VALID starts a clean frame with MOD_IDX taken from IDX_0.
- Edges: DEPTH=1 → a single valid cycle at L. Widths INTENSITY_WIDTH=10, MOD_WIDTH=12 with 1023×4095 → 4189185.
